// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, return-address stack and run/halt/fault
// control for the instruction fetch path.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   op_valid, op        control-flow op from decode (6-7 act as NEXT)
//   target              absolute address for JUMP / CALL
//   offset, cond        signed BRANCH displacement and taken flag
//   resume              leave HALT
//   fetch_ready         instruction memory accepts pc this cycle
//   pc, pc_valid        registered fetch address and request
//   halted              sequencer is in HALT
//   fault               sticky code: 0 none, 1 overflow, 2 underflow
//   sp                  return-address stack occupancy
module pc_sequencer #(
   parameter int IMEM_ADDR_WIDTH = 8,
   parameter int STACK_DEPTH     = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         op_valid,
   input  logic [2:0]                   op,
   input  logic [IMEM_ADDR_WIDTH-1:0]   target,
   input  logic [7:0]                   offset,
   input  logic                         cond,
   input  logic                         resume,
   input  logic                         fetch_ready,
   output logic [IMEM_ADDR_WIDTH-1:0]   pc,
   output logic                         pc_valid,
   output logic                         halted,
   output logic [1:0]                   fault,
   output logic [$clog2(STACK_DEPTH):0] sp
);

   localparam int AW   = IMEM_ADDR_WIDTH;
   localparam int IDXW = $clog2(STACK_DEPTH);
   localparam int SPW  = IDXW + 1;

   localparam logic [2:0] OP_JUMP   = 3'd1;
   localparam logic [2:0] OP_BRANCH = 3'd2;
   localparam logic [2:0] OP_CALL   = 3'd3;
   localparam logic [2:0] OP_RET    = 3'd4;
   localparam logic [2:0] OP_HALT   = 3'd5;

   localparam logic [1:0] FLT_OVF = 2'd1;
   localparam logic [1:0] FLT_UNF = 2'd2;

   typedef enum logic [1:0] {
      S_RUN,
      S_HALT,
      S_FAULT
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [AW-1:0]   stack [STACK_DEPTH];
   logic [AW-1:0]   pc_nxt;
   logic [AW-1:0]   pc_inc;
   logic [AW-1:0]   off_ext;
   logic [SPW-1:0]  sp_nxt;
   logic [1:0]      fault_nxt;
   logic [IDXW-1:0] push_idx;
   logic [IDXW-1:0] pop_idx;
   logic            push;
   logic            step;
   logic            stack_full;
   logic            stack_empty;

   assign pc_inc      = pc + AW'(1);
   // size cast of a signed value sign-extends (or truncates) to AW
   assign off_ext     = AW'($signed(offset));
   assign push_idx    = sp[IDXW-1:0];
   assign pop_idx     = IDXW'(sp - SPW'(1));
   assign stack_full  = (sp == SPW'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   // pc_valid is low in the cycle after reset, so no step happens there
   assign step        = pc_valid && fetch_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      sp_nxt    = sp;
      fault_nxt = fault;
      push      = 1'b0;
      unique case (state)
         S_RUN: begin
            if (step) begin
               pc_nxt = pc_inc;
               if (op_valid) begin
                  case (op)
                     OP_JUMP: pc_nxt = target;
                     OP_BRANCH: begin
                        if (cond) pc_nxt = pc + off_ext;
                     end
                     OP_CALL: begin
                        if (stack_full) begin
                           pc_nxt    = pc;
                           fault_nxt = FLT_OVF;
                           state_nxt = S_FAULT;
                        end else begin
                           push   = 1'b1;
                           pc_nxt = target;
                           sp_nxt = sp + SPW'(1);
                        end
                     end
                     OP_RET: begin
                        if (stack_empty) begin
                           pc_nxt    = pc;
                           fault_nxt = FLT_UNF;
                           state_nxt = S_FAULT;
                        end else begin
                           pc_nxt = stack[pop_idx];
                           sp_nxt = sp - SPW'(1);
                        end
                     end
                     OP_HALT: state_nxt = S_HALT;
                     default: ;
                  endcase
               end
            end
         end
         S_HALT: begin
            if (resume) state_nxt = S_RUN;
         end
         S_FAULT: ;
         default: state_nxt = S_FAULT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_RUN;
         pc       <= '0;
         sp       <= '0;
         fault    <= '0;
         pc_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         sp       <= sp_nxt;
         fault    <= fault_nxt;
         pc_valid <= (state_nxt == S_RUN);
         halted   <= (state_nxt == S_HALT);
         if (push) stack[push_idx] <= pc_inc;
      end
   end

endmodule
